// File: rtl/counter_loadable.sv
// counter_loadable: presettable up-counter with load, enable gate and a registered wrap pulse
module counter_loadable #(
    parameter int WIDTH       = 8,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             count,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_value,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] next_value;
    logic             next_wrap;

    // The extra MSB of sum is the carry out, which only feeds wrap.
    always_comb begin
        sum        = {1'b0, counter_value} + (WIDTH + 1)'(1);
        next_value = !enable ? counter_value :
                     load    ? load_value    :
                     count   ? sum[WIDTH-1:0] : counter_value;
        next_wrap  = enable && !load && count && sum[WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter_value <= RST_VAL;
            wrap          <= 1'b0;
        end else begin
            counter_value <= next_value;
            wrap          <= next_wrap;
        end
    end

    a_hold: assert property (@(posedge clock) disable iff (!reset)
        $past(reset) && !$past(enable) |-> counter_value == $past(counter_value) && !wrap);

    a_load: assert property (@(posedge clock) disable iff (!reset)
        $past(reset) && $past(enable && load) |-> counter_value == $past(load_value) && !wrap);

    a_inc: assert property (@(posedge clock) disable iff (!reset)
        $past(reset) && $past(enable && !load && count) |->
            counter_value == WIDTH'($past(counter_value) + 1'b1) &&
            wrap == ($past(counter_value) == '1));

    a_wrap_pulse: assert property (@(posedge clock) disable iff (!reset)
        wrap |=> (WIDTH == 1 || !wrap));
endmodule

// File: tb/tb_counter_loadable.sv
// tb_counter_loadable: directed checks of reset, gating, load priority and wrap
module tb_counter_loadable;
    logic       clock = 1'b0;
    logic       reset, enable, count, load;
    logic [7:0] load_value;
    logic [7:0] cv0, cv1;
    logic       wrap0, wrap1;
    int         total = 0;
    int         bad = 0;

    always #5 clock = ~clock;

    counter_loadable #(.WIDTH(8), .RESET_VALUE(0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .count(count), .load(load),
        .load_value(load_value), .counter_value(cv0), .wrap(wrap0)
    );

    counter_loadable #(.WIDTH(8), .RESET_VALUE(16)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .count(count), .load(load),
        .load_value(load_value), .counter_value(cv1), .wrap(wrap1)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect0(input string name, input logic [7:0] v, input logic w);
        total++;
        if (cv0 !== v) begin
            bad++;
            $display("FAIL %s value: got %h want %h", name, cv0, v);
        end
        total++;
        if (wrap0 !== w) begin
            bad++;
            $display("FAIL %s wrap: got %b want %b", name, wrap0, w);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; count = 1'b0; load = 1'b0; load_value = 8'hDE;
        #2 reset = 1'b0;
        #1;
        expect0("reset_async", 8'h00, 1'b0);
        total++;
        if (cv1 !== 8'h10) begin
            bad++;
            $display("FAIL reset_value_dut1: got %h want 10", cv1);
        end
        step();
        expect0("reset_held", 8'h00, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_no_enable();
        count = 1'b1;
        step();
        expect0("count_disabled", 8'h00, 1'b0);
    endtask

    task automatic test_count();
        enable = 1'b1;
        step();
        expect0("count_1", 8'h01, 1'b0);
        step();
        expect0("count_2", 8'h02, 1'b0);
    endtask

    task automatic test_load_gate();
        enable = 1'b0; count = 1'b0; load = 1'b1;
        step();
        expect0("load_disabled", 8'h02, 1'b0);
        enable = 1'b1;
        step();
        expect0("load_de", 8'hDE, 1'b0);
        load = 1'b0; count = 1'b1; load_value = 8'h5A;
        step();
        expect0("count_df", 8'hDF, 1'b0);
        step();
        expect0("count_e0", 8'hE0, 1'b0);
        enable = 1'b0;
        step();
        expect0("hold_e0", 8'hE0, 1'b0);
    endtask

    task automatic test_load_wrap();
        enable = 1'b1; load = 1'b1; count = 1'b1; load_value = 8'hFF;
        step();
        expect0("load_wins", 8'hFF, 1'b0);
        load = 1'b0; load_value = 8'h33;
        step();
        expect0("wrap_edge", 8'h00, 1'b1);
        step();
        expect0("after_wrap", 8'h01, 1'b0);
    endtask

    task automatic test_reset_mid();
        step();
        total++;
        if (cv1 !== 8'h02) begin
            bad++;
            $display("FAIL mid_pre: got %h want 02", cv1);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (cv1 !== 8'h10 || wrap1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: got %h/%b want 10/0", cv1, wrap1);
        end
        step();
        reset = 1'b1;
        total++;
        if (cv1 !== 8'h10) begin
            bad++;
            $display("FAIL mid_held: got %h want 10", cv1);
        end
        step();
        total++;
        if (cv1 !== 8'h11) begin
            bad++;
            $display("FAIL resume_11: got %h want 11", cv1);
        end
        step();
        total++;
        if (cv1 !== 8'h12) begin
            bad++;
            $display("FAIL resume_12: got %h want 12", cv1);
        end
        expect0("dut0_resume", 8'h02, 1'b0);
    endtask

    initial begin
        test_reset();
        test_no_enable();
        test_count();
        test_load_gate();
        test_load_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_loadable.md
Name: counter_loadable

Overview:
Synchronous up-counter, parameterizable width, with a parallel-load port and a global enable gate. Used wherever the datapath needs a resettable, presettable register that advances by one per cycle, such as a program counter or loop counter. All state changes happen on the rising clock edge, except reset, which is asynchronous.

Parameters:
WIDTH, 8, bit width of load_value and counter_value.
RESET_VALUE, 0, value counter_value takes while reset is asserted; truncated to WIDTH bits.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset. Asserted (0) forces counter_value to RESET_VALUE immediately.
enable  input  1  global gate; when 0, load and count are ignored.
count  input  1  increment request; effective only when enable=1.
load  input  1  parallel-load request; effective only when enable=1.
load_value  input  WIDTH  value captured on an effective load.
counter_value  output  WIDTH  current registered count.
wrap  output  1  registered one-cycle pulse, set on the edge where an increment rolls all-ones over to zero.

Behaviour:
- Reset (reset=0):
  - Asynchronous; takes effect without a clock edge.
  - counter_value = RESET_VALUE, wrap = 0.
  - Held for as long as reset=0; overrides every other input.
  - Release (0->1) is synchronised by the integrator; the block itself samples normally from the first rising edge after release.
- Priority at each rising edge with reset=1 (highest first):
  1. enable=0: counter_value holds, regardless of load/count; wrap <= 0.
  2. enable=1, load=1: counter_value <= load_value; wrap <= 0. Load wins over a simultaneous count=1.
  3. enable=1, load=0, count=1: counter_value <= counter_value + 1, modulo 2^WIDTH.
     - If the old value was all-ones: result is 0 and wrap <= 1 for that cycle.
     - Otherwise wrap <= 0.
  4. enable=1, load=0, count=0: counter_value holds; wrap <= 0.
- Latency:
  - Load and increment are both visible on counter_value one edge after the qualifying inputs are sampled.
  - No combinational path from any input to counter_value or wrap.
- Values before the first reset are undefined (X in simulation); the system is required to reset before use.
- Arithmetic: unsigned, no saturation. The carry out of the MSB drives wrap only.
- Load of all-ones followed by count produces 0 with wrap=1 on the next edge.
- Reset asserted mid-sequence discards any pending load/count. After release, counting resumes from RESET_VALUE.
- load_value is sampled only on an effective load edge; changes at other times have no effect.

Decomposition:
- No shared package; WIDTH and RESET_VALUE are module parameters only.
- Single module with one always_ff block for counter_value/wrap and a combinational next-state expression; no sub-modules.
- RTL plus assertions (priority, wrap pulse width, hold when enable=0) sized 120-200 lines.

Test Plan:
1. Reset, WIDTH=8, load_value=0xDE: drive reset=0 for one cycle between edges -> counter_value becomes 0x00 immediately, before any clock edge; wrap=0.
2. Count without enable: reset=1, enable=0, count=1 for one cycle -> counter_value stays 0x00.
3. Count with enable: enable=1, count=1 for two edges -> 0x01 then 0x02.
4. Load gating, then load:
   - enable=0, count=0, load=1 for one edge -> stays 0x02.
   - Then enable=1 for one edge -> 0xDE.
   - Then load=0, count=1 for two edges -> 0xDF, 0xE0.
   - Then enable=0 -> holds 0xE0.
5. Simultaneous load+count and wrap:
   - enable=1, load=1, count=1, load_value=0xFF -> 0xFF (load wins).
   - Then load=0 for one edge -> 0x00 with wrap=1 for exactly one cycle.
   - Next edge -> 0x01, wrap=0.
6. Reset mid-operation, RESET_VALUE=0x10:
   - While counting, assert reset=0 asynchronously -> counter_value=0x10 before the next edge.
   - Deassert -> counting resumes 0x11, 0x12.
